stopwatch_ctrl: RTL

Front-end control stage directly upstream of stopwatch_top. Synchronises and debounces the raw start/stop/clr buttons and dir switch, then runs the run/pause/clear state machine. Generates the single-cycle count-enable tick, clear pulse and latched direction that drive the digit counters. Also stops a down-count at zero.

---
 rtl/stopwatch_ctrl_if.sv | 36 +++
 rtl/stopwatch_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch control bus: raw operator inputs, counter feedback and control outputs.
// STOPWATCH_LAP_EN adds lap_btn and freeze.
interface stopwatch_ctrl_if;
    logic       start_btn;
    logic       stop_btn;
    logic       clr_btn;
    logic       dir_sw;
    logic       at_zero;
    logic       count_en;
    logic       clr_out;
    logic       dir;
    logic       running;
    logic [1:0] state;
`ifdef STOPWATCH_LAP_EN
    logic       lap_btn;
    logic       freeze;

    modport master (
        output start_btn, stop_btn, clr_btn, dir_sw, at_zero, lap_btn,
        input  count_en, clr_out, dir, running, state, freeze
    );
    modport slave (
        input  start_btn, stop_btn, clr_btn, dir_sw, at_zero, lap_btn,
        output count_en, clr_out, dir, running, state, freeze
    );
`else
    modport master (
        output start_btn, stop_btn, clr_btn, dir_sw, at_zero,
        input  count_en, clr_out, dir, running, state
    );
    modport slave (
        input  start_btn, stop_btn, clr_btn, dir_sw, at_zero,
        output count_en, clr_out, dir, running, state
    );
`endif
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-end: button sync/debounce, run/pause/clear FSM and tick prescaler.
// Optional lap/freeze support is enabled with `define STOPWATCH_LAP_EN.
module stopwatch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TICK_DIV        = 1000000
) (
    input  logic            clk,
    input  logic            rst,
    stopwatch_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

`ifdef STOPWATCH_LAP_EN
    localparam int NCH = 5;
`else
    localparam int NCH = 4;
`endif
    localparam int CH_DIR   = 0;
    localparam int CH_START = 1;
    localparam int CH_STOP  = 2;
    localparam int CH_CLR   = 3;
`ifdef STOPWATCH_LAP_EN
    localparam int CH_LAP   = 4;
`endif

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    // dir's debounced level starts at "up" so it agrees with the reset dir
    localparam logic [NCH-1:0] LVL_RST = NCH'(1);

    logic [NCH-1:0] raw;
    logic [NCH-1:0] sync1;
    logic [NCH-1:0] sync2;
    logic [NCH-1:0] level;
    logic [NCH-1:1] level_q;
    logic [NCH-1:1] press;
    logic [DW-1:0]  db_cnt [NCH];

    always_comb begin
        raw           = '0;
        raw[CH_DIR]   = bus.dir_sw;
        raw[CH_START] = bus.start_btn;
        raw[CH_STOP]  = bus.stop_btn;
        raw[CH_CLR]   = bus.clr_btn;
`ifdef STOPWATCH_LAP_EN
        raw[CH_LAP]   = bus.lap_btn;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= LVL_RST;
            level_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_q <= level[NCH-1:1];
            for (int i = 0; i < NCH; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press = level[NCH-1:1] & ~level_q;

    logic start_p;
    logic stop_p;
    logic clr_p;
    assign start_p = press[CH_START];
    assign stop_p  = press[CH_STOP];
    assign clr_p   = press[CH_CLR];

    state_t        state, state_n;
    logic [PW-1:0] presc, presc_n;
    logic          dir_q, dir_n;
    logic          clr_q, clr_n;
    logic          run_q;
    logic          tick;
    logic          term;
`ifdef STOPWATCH_LAP_EN
    logic          lap_p;
    logic          freeze_q, freeze_n;
    assign lap_p = press[CH_LAP];
`endif

    // a down-count sitting at zero must never receive another tick
    assign tick = (state == RUN) && (presc == TICK_LAST);
    assign term = !dir_q && bus.at_zero;

    always_comb begin
        state_n  = state;
        presc_n  = presc;
        dir_n    = dir_q;
        clr_n    = 1'b0;
`ifdef STOPWATCH_LAP_EN
        freeze_n = freeze_q;
`endif
        if (state == IDLE || state == PAUSE) begin
            dir_n = level[CH_DIR];
        end
        if (state == RUN) begin
            presc_n = (presc == TICK_LAST) ? '0 : presc + 1'b1;
        end
        if (clr_p) begin
            state_n  = IDLE;
            clr_n    = 1'b1;
            presc_n  = '0;
`ifdef STOPWATCH_LAP_EN
            freeze_n = 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_p && !term) begin
                        state_n = RUN;
                        presc_n = '0;
                    end
                end
                RUN: begin
                    if (stop_p) begin
                        state_n = PAUSE;
                    end else if (tick && term) begin
                        state_n  = DONE;
`ifdef STOPWATCH_LAP_EN
                        freeze_n = 1'b0;
                    end else if (lap_p) begin
                        freeze_n = !freeze_q;
`endif
                    end
                end
                PAUSE: begin
                    if (start_p) begin
                        state_n = RUN;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            presc    <= '0;
            dir_q    <= 1'b1;
            clr_q    <= 1'b0;
            run_q    <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            freeze_q <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            presc    <= presc_n;
            dir_q    <= dir_n;
            clr_q    <= clr_n;
            run_q    <= (state_n == RUN);
`ifdef STOPWATCH_LAP_EN
            freeze_q <= freeze_n;
`endif
        end
    end

    assign bus.count_en = tick && !term;
    assign bus.clr_out  = clr_q;
    assign bus.dir      = dir_q;
    assign bus.running  = run_q;
    assign bus.state    = state;
`ifdef STOPWATCH_LAP_EN
    assign bus.freeze   = freeze_q;
`endif

endmodule
